// File: rtl/comm_pkg.sv
// Shared serial-comm definitions: frame FSM state encoding reused by the
// shift register and the SPI master.
package comm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } comm_state_e;

endpackage : comm_pkg

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load starts a frame of exactly WIDTH
// serial shifts (direction set by MSB_FIRST); o_Done pulses for one cycle
// when the frame completes. Gaps in i_Shift_En stretch the frame.
module univ_shift_reg
    import comm_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Ld,
    input  logic [WIDTH-1:0] i_Data,
    input  logic             i_Shift_En,
    input  logic             i_Ser,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Ser,
    output logic             o_Busy,
    output logic             o_Done
);

    // Counter holds 0..WIDTH, so it never wraps within a frame.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    comm_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state, register and counter update; load only outside SHIFT.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (i_Ld) begin
                    shreg_d = i_Data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (i_Shift_En) begin
                    if (MSB_FIRST) begin
                        shreg_d = {shreg_q[WIDTH-2:0], i_Ser};
                    end else begin
                        shreg_d = {i_Ser, shreg_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, register and counter flops with synchronous reset priority.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_Data = shreg_q;
    assign o_Ser  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign o_Busy = (state_q == SHIFT);
    assign o_Done = (state_q == DONE);

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: one MSB-first and one LSB-first
// instance share stimulus; table vectors plus hand-written corner sequences.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst, ld, sh, ser;
    logic [7:0] data;

    logic [7:0] m_data, l_data;
    logic       m_ser, l_ser, m_busy, l_busy, m_done, l_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit       sel;       // 0 = MSB-first instance, 1 = LSB-first
        bit       ld;
        bit [7:0] data;
        bit       sh;
        bit       ser;
        bit [7:0] exp_data;
        bit       exp_ser;
        bit       exp_busy;
        bit       exp_done;
    } vec_t;

    vec_t tbl [0:20];

    univ_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .i_Clk(clk), .i_Rst(rst), .i_Ld(ld), .i_Data(data),
        .i_Shift_En(sh), .i_Ser(ser),
        .o_Data(m_data), .o_Ser(m_ser), .o_Busy(m_busy), .o_Done(m_done)
    );

    univ_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .i_Clk(clk), .i_Rst(rst), .i_Ld(ld), .i_Data(data),
        .i_Shift_En(sh), .i_Ser(ser),
        .o_Data(l_data), .o_Ser(l_ser), .o_Busy(l_busy), .o_Done(l_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_m(input string nm, input logic [7:0] d, input logic b, input logic dn);
        chk({nm, " data"}, 64'(m_data), 64'(d));
        chk({nm, " busy"}, 64'(m_busy), 64'(b));
        chk({nm, " done"}, 64'(m_done), 64'(dn));
    endtask

    initial begin
        logic [7:0] exp;

        // MSB-first: load 8'hAC, i_Ser=1 continuously
        tbl[0]  = '{1'b0, 1'b1, 8'hAC, 1'b1, 1'b1, 8'hAC, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h59, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hB3, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h67, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hCF, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h9F, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3F, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        // LSB-first: load 8'hAC, i_Ser=0 continuously
        tbl[11] = '{1'b1, 1'b1, 8'hAC, 1'b1, 1'b0, 8'hAC, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h56, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h2B, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h15, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h0A, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[20] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

        // Reset held 2 cycles with a competing load of 8'hFF
        rst = 1'b1; ld = 1'b1; data = 8'hFF; sh = 1'b1; ser = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_m("reset msb", 8'h00, 1'b0, 1'b0);
            chk("reset msb ser", 64'(m_ser), 64'd0);
            chk("reset lsb data", 64'(l_data), 64'h00);
            chk("reset lsb ser", 64'(l_ser), 64'd0);
        end
        rst = 1'b0; ld = 1'b0; sh = 1'b0; ser = 1'b0; data = 8'h00;
        step();

        // Table-driven frames
        for (int i = 0; i <= 20; i++) begin
            ld = tbl[i].ld; data = tbl[i].data; sh = tbl[i].sh; ser = tbl[i].ser;
            step();
            if (tbl[i].sel) begin
                chk($sformatf("lsb v%0d data", i), 64'(l_data), 64'(tbl[i].exp_data));
                chk($sformatf("lsb v%0d ser", i),  64'(l_ser),  64'(tbl[i].exp_ser));
                chk($sformatf("lsb v%0d busy", i), 64'(l_busy), 64'(tbl[i].exp_busy));
                chk($sformatf("lsb v%0d done", i), 64'(l_done), 64'(tbl[i].exp_done));
            end else begin
                chk($sformatf("msb v%0d data", i), 64'(m_data), 64'(tbl[i].exp_data));
                chk($sformatf("msb v%0d ser", i),  64'(m_ser),  64'(tbl[i].exp_ser));
                chk($sformatf("msb v%0d busy", i), 64'(m_busy), 64'(tbl[i].exp_busy));
                chk($sformatf("msb v%0d done", i), 64'(m_done), 64'(tbl[i].exp_done));
            end
        end

        // Gap: load AA, shift 3, idle 5, shift 5 (i_Ser=0)
        ld = 1'b1; data = 8'hAA; sh = 1'b0; ser = 1'b0;
        step();
        chk_m("gap load", 8'hAA, 1'b1, 1'b0);
        ld = 1'b0; sh = 1'b1; exp = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            step();
            exp = exp << 1;
            chk_m($sformatf("gap pre s%0d", i), exp, 1'b1, 1'b0);
        end
        sh = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_m($sformatf("gap hold c%0d", i), 8'h50, 1'b1, 1'b0);
        end
        sh = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            exp = exp << 1;
            chk_m($sformatf("gap post s%0d", i), exp, (i != 4), (i == 4));
        end
        sh = 1'b0;
        step();
        chk_m("gap idle", 8'h00, 1'b0, 1'b0);

        // Mid-frame load of 55 after 2 shifts is ignored
        ld = 1'b1; data = 8'hAC; sh = 1'b0;
        step();
        ld = 1'b0; sh = 1'b1; exp = 8'hAC;
        for (int i = 0; i < 2; i++) begin
            step();
            exp = exp << 1;
        end
        chk_m("midld pre", 8'hB0, 1'b1, 1'b0);
        ld = 1'b1; data = 8'h55; sh = 1'b0;
        step();
        chk_m("midld ignored", 8'hB0, 1'b1, 1'b0);
        ld = 1'b0; sh = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            exp = exp << 1;
            chk_m($sformatf("midld s%0d", i), exp, (i != 5), (i == 5));
        end

        // Back-to-back: load in DONE cycle, shift request loses to load
        ld = 1'b1; data = 8'h3C; sh = 1'b1; ser = 1'b1;
        step();
        chk_m("b2b load", 8'h3C, 1'b1, 1'b0);

        // Reset after 4 shifts aborts frame without o_Done
        ld = 1'b0; exp = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            step();
            exp = {exp[6:0], 1'b1};
        end
        chk_m("rstmid pre", 8'hCF, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        chk_m("rstmid reset", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_m($sformatf("rstmid after c%0d", i), 8'h00, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_univ_shift_reg
